ddr_sys_master: RTL and testbench

- System-side initiator for the DDR controller top: it drives the controller's sys_* request interface and consumes its data strobes.
- Generates the 200 us power-up delay flag and waits for DDR init done.
- Converts a simple client request/ready interface into one-cycle address strobes plus fixed-length write and read bursts.
- Sits between framebuffer clients (scan-out reader, remote update writer) and the DDR controller.

---
 rtl/ddr_sys_master.sv | 139 +++++++++++++
 tb/tb_ddr_sys_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_sys_master.sv
// System-side initiator for the DDR controller: power-up delay, init wait, and conversion of
// client requests into one-cycle address strobes followed by fixed-length data bursts.
module ddr_sys_master #(
  parameter int unsigned DSIZE      = 32,
  parameter int unsigned AWIDTH     = 15,
  parameter int unsigned BURST_LEN  = 2,
  parameter int unsigned DLY_CYCLES = 20000,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sys_init_done,
  input  logic              sys_in_en,
  input  logic              sys_out_en,
  input  logic [DSIZE-1:0]  sysdo,
  output logic              sys_dly_200us,
  output logic              sys_adsn,
  output logic [AWIDTH-1:0] sys_add,
  output logic              sys_r_wn,
  output logic [DSIZE-1:0]  sysdi,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DSIZE-1:0]  wr_data,
  output logic              wr_data_pop,
  output logic [DSIZE-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DlyW   = $clog2(DLY_CYCLES + 1);
  localparam int unsigned CntMax = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BeatW  = $clog2(BURST_LEN + 1);

  localparam logic [DlyW-1:0]  DlyLast  = DlyW'(DLY_CYCLES - 1);
  localparam logic [CntW-1:0]  ToLast   = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0]  GapLast  = CntW'(GAP_CYC - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    StDly, StInitw, StIdle, StAddr, StWdata, StRdata, StGap
  } state_e;

  state_e            state_q;
  logic [DlyW-1:0]   dly_cnt_q;
  // Shared between beat timeout in the data phases and the post-burst gap count.
  logic [CntW-1:0]   to_cnt_q;
  logic [BeatW-1:0]  beat_cnt_q;
  logic              beat_hit;

  assign beat_hit    = ((state_q == StWdata) && sys_in_en) || ((state_q == StRdata) && sys_out_en);
  assign req_ready   = (state_q == StIdle) && sys_init_done;
  assign busy        = state_q inside {StAddr, StWdata, StRdata, StGap};
  assign sysdi       = (state_q == StWdata) ? wr_data : '0;
  assign wr_data_pop = (state_q == StWdata) && sys_in_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StDly;
      dly_cnt_q     <= '0;
      to_cnt_q      <= '0;
      beat_cnt_q    <= '0;
      sys_dly_200us <= 1'b0;
      sys_adsn      <= 1'b1;
      sys_add       <= '0;
      sys_r_wn      <= 1'b1;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      err           <= 1'b0;
    end else begin
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      unique case (state_q)
        StDly: begin
          if (dly_cnt_q == DlyLast) begin
            sys_dly_200us <= 1'b1;
            state_q       <= StInitw;
          end else begin
            dly_cnt_q <= dly_cnt_q + DlyW'(1);
          end
        end
        StInitw: begin
          if (sys_init_done) state_q <= StIdle;
        end
        StIdle: begin
          if (!sys_init_done) begin
            state_q <= StInitw;
          end else if (req_valid) begin
            // Request is captured straight into the strobe registers, which then hold.
            sys_adsn <= 1'b0;
            sys_add  <= req_addr;
            sys_r_wn <= ~req_wr;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          sys_adsn   <= 1'b1;
          beat_cnt_q <= '0;
          to_cnt_q   <= '0;
          state_q    <= sys_r_wn ? StRdata : StWdata;
        end
        StWdata, StRdata: begin
          if (beat_hit) begin
            beat_cnt_q <= beat_cnt_q + BeatW'(1);
            to_cnt_q   <= '0;
            if (state_q == StRdata) begin
              rd_data  <= sysdo;
              rd_valid <= 1'b1;
              rd_last  <= (beat_cnt_q == BeatLast);
            end
            if (beat_cnt_q == BeatLast) state_q <= StGap;
          end else if (to_cnt_q == ToLast) begin
            err      <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= StGap;
          end else begin
            to_cnt_q <= to_cnt_q + CntW'(1);
          end
        end
        StGap: begin
          if (to_cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StDly;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_sys_master.sv
// Randomised bench for ddr_sys_master: a transaction-level model predicts strobe, data,
// timeout and gap behaviour cycle by cycle from the request and controller strobe pattern.
module tb_ddr_sys_master;

  localparam int unsigned DSIZE      = 32;
  localparam int unsigned AWIDTH     = 15;
  localparam int unsigned BURST_LEN  = 2;
  localparam int unsigned DLY_CYCLES = 16;
  localparam int unsigned TIMEOUT    = 64;
  localparam int unsigned GAP_CYC    = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sys_init_done = 1'b1;
  logic              sys_in_en = 1'b0;
  logic              sys_out_en = 1'b0;
  logic [DSIZE-1:0]  sysdo = '0;
  logic              sys_dly_200us;
  logic              sys_adsn;
  logic [AWIDTH-1:0] sys_add;
  logic              sys_r_wn;
  logic [DSIZE-1:0]  sysdi;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [AWIDTH-1:0] req_addr = '0;
  logic [DSIZE-1:0]  wr_data = '0;
  logic              wr_data_pop;
  logic [DSIZE-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  ddr_sys_master #(
    .DSIZE(DSIZE), .AWIDTH(AWIDTH), .BURST_LEN(BURST_LEN),
    .DLY_CYCLES(DLY_CYCLES), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .sys_init_done(sys_init_done), .sys_in_en(sys_in_en),
    .sys_out_en(sys_out_en), .sysdo(sysdo), .sys_dly_200us(sys_dly_200us),
    .sys_adsn(sys_adsn), .sys_add(sys_add), .sys_r_wn(sys_r_wn), .sysdi(sysdi),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .wr_data(wr_data), .wr_data_pop(wr_data_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .busy(busy), .err(err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Expected read-return outputs for the current cycle (produced by the previous cycle's beat).
  logic             exp_rv = 1'b0;
  logic             exp_rl = 1'b0;
  logic [DSIZE-1:0] exp_rd = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_rd();
    check("rd_valid", 64'(rd_valid), 64'(exp_rv));
    if (exp_rv) check("rd_data", 64'(rd_data), 64'(exp_rd));
    check("rd_last", 64'(rd_last), 64'(exp_rl));
  endtask

  task automatic check_reset();
    check("rst_dly", 64'(sys_dly_200us), 64'd0);
    check("rst_adsn", 64'(sys_adsn), 64'd1);
    check("rst_add", 64'(sys_add), 64'd0);
    check("rst_r_wn", 64'(sys_r_wn), 64'd1);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_pop", 64'(wr_data_pop), 64'd0);
    check("rst_sysdi", 64'(sysdi), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
  endtask

  // Controller strobe policy: 0 never, 1 coin flip, 2 only on the last cycle before timeout,
  // otherwise first beat after dly empty cycles then back-to-back.
  function automatic bit pick(int pol, int dly, int beats, int idle);
    case (pol)
      0:       return 1'b0;
      1:       return 1'($urandom_range(0, 1));
      2:       return idle == int'(TIMEOUT) - 1;
      default: return (beats > 0) || (idle >= dly);
    endcase
  endfunction

  task automatic power_up();
    reset_n       = 1'b0;
    sys_init_done = 1'b1;
    req_valid     = 1'b0;
    sys_in_en     = 1'b0;
    sys_out_en    = 1'b0;
    exp_rv        = 1'b0;
    exp_rl        = 1'b0;
    @(negedge clk);
    #1;
    check_reset();
    reset_n = 1'b1;
    for (int i = 1; i <= int'(DLY_CYCLES) + 1; i++) begin
      @(negedge clk);
      #1;
      check("dly_200us", 64'(sys_dly_200us), 64'(i >= int'(DLY_CYCLES)));
      check("pu_ready", 64'(req_ready), 64'(i > int'(DLY_CYCLES)));
      check("pu_busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic do_xfer(input bit wr, input logic [AWIDTH-1:0] addr, input int pol,
                         input int dly, input logic [DSIZE-1:0] d0, input logic [DSIZE-1:0] d1);
    logic [DSIZE-1:0] bv [2];
    logic [DSIZE-1:0] sd;
    int beats;
    int idle;
    bit en;
    bit abort;
    bv[0] = d0;
    bv[1] = d1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_wr     = wr;
    req_addr   = addr;
    sys_in_en  = 1'b0;
    sys_out_en = 1'b0;
    #1;
    check("acc_ready", 64'(req_ready), 64'd1);
    check("acc_busy", 64'(busy), 64'd0);
    check("acc_adsn", 64'(sys_adsn), 64'd1);
    check("acc_err", 64'(err), 64'd0);
    check_rd();
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_wr    = 1'($urandom);
    req_addr  = AWIDTH'($urandom);
    #1;
    check("adsn", 64'(sys_adsn), 64'd0);
    check("add", 64'(sys_add), 64'(addr));
    check("r_wn", 64'(sys_r_wn), 64'(!wr));
    check("strobe_ready", 64'(req_ready), 64'd0);
    check("strobe_busy", 64'(busy), 64'd1);
    beats = 0;
    idle  = 0;
    abort = 1'b0;
    exp_rv = 1'b0;
    exp_rl = 1'b0;
    while (beats < int'(BURST_LEN) && !abort) begin
      @(negedge clk);
      en = pick(pol, dly, beats, idle);
      sd = DSIZE'($urandom);
      if (en && !wr) sd = bv[beats];
      if (wr) begin
        sys_in_en  = en;
        sys_out_en = 1'($urandom);
        wr_data    = bv[beats];
      end else begin
        sys_out_en = en;
        sys_in_en  = 1'($urandom);
        wr_data    = DSIZE'($urandom);
      end
      sysdo     = sd;
      req_valid = 1'($urandom);
      #1;
      check("data_adsn", 64'(sys_adsn), 64'd1);
      check("data_add_hold", 64'(sys_add), 64'(addr));
      check("data_busy", 64'(busy), 64'd1);
      check("data_err", 64'(err), 64'd0);
      check("data_ready", 64'(req_ready), 64'd0);
      check("pop", 64'(wr_data_pop), 64'(wr && en));
      check("sysdi", 64'(sysdi), wr ? 64'(wr_data) : 64'd0);
      check_rd();
      exp_rv = !wr && en;
      exp_rd = sd;
      exp_rl = exp_rv && (beats == int'(BURST_LEN) - 1);
      if (en) begin
        beats++;
        idle = 0;
      end else begin
        idle++;
        if (idle == int'(TIMEOUT)) abort = 1'b1;
      end
    end
    for (int g = 0; g < int'(GAP_CYC); g++) begin
      @(negedge clk);
      sys_in_en  = 1'($urandom);
      sys_out_en = 1'($urandom);
      wr_data    = DSIZE'($urandom);
      sysdo      = DSIZE'($urandom);
      req_valid  = 1'($urandom);
      #1;
      check("gap_busy", 64'(busy), 64'd1);
      check("gap_err", 64'(err), 64'(g == 0 && abort));
      check("gap_pop", 64'(wr_data_pop), 64'd0);
      check("gap_sysdi", 64'(sysdi), 64'd0);
      check("gap_ready", 64'(req_ready), 64'd0);
      check_rd();
      exp_rv = 1'b0;
      exp_rl = 1'b0;
    end
  endtask

  initial begin
    int pol;
    int dly;
    power_up();

    do_xfer(1'b1, 15'h1A2B, 3, 2, 32'hDEAD0001, 32'hDEAD0002);
    do_xfer(1'b0, 15'h0004, 3, 0, 32'h11111111, 32'h22222222);
    do_xfer(1'b0, 15'h0100, 0, 0, 32'h0, 32'h0);
    do_xfer(1'b1, 15'h0200, 2, 0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    do_xfer(1'b0, 15'h7FFF, 2, 0, 32'hFFFFFFFF, 32'h00000001);

    // Stray read strobes and init loss while idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      sys_out_en = 1'b1;
      sys_in_en  = 1'b1;
      #1;
      check("idle_stray_rv", 64'(rd_valid), 64'd0);
      check("idle_stray_pop", 64'(wr_data_pop), 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sys_init_done = 1'b0;
      req_valid     = 1'b1;
      sys_out_en    = 1'b0;
      sys_in_en     = 1'b0;
      #1;
      check("noinit_ready", 64'(req_ready), 64'd0);
      check("noinit_adsn", 64'(sys_adsn), 64'd1);
      check("noinit_busy", 64'(busy), 64'd0);
      check("noinit_rv", 64'(rd_valid), 64'd0);
    end
    @(negedge clk);
    sys_init_done = 1'b1;
    #1;
    check("initw_ready", 64'(req_ready), 64'd0);
    check("initw_adsn", 64'(sys_adsn), 64'd1);
    do_xfer(1'b1, 15'h0321, 3, 1, 32'h01234567, 32'h89ABCDEF);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 7))
        0:       pol = 0;
        1:       pol = 2;
        2, 3, 4: pol = 1;
        default: pol = 3;
      endcase
      dly = int'($urandom_range(0, 5));
      do_xfer(1'($urandom), AWIDTH'($urandom), pol, dly, DSIZE'($urandom), DSIZE'($urandom));
    end

    // Reset in the middle of a write burst.
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 15'h0555;
    #1;
    check("mid_acc_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("mid_adsn", 64'(sys_adsn), 64'd0);
    @(negedge clk);
    sys_in_en = 1'b1;
    wr_data   = 32'hCAFE0001;
    #1;
    check("mid_pop", 64'(wr_data_pop), 64'd1);
    check("mid_sysdi", 64'(sysdi), 64'h00000000CAFE0001);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset();
    power_up();
    do_xfer(1'b0, 15'h0ABC, 3, 0, 32'h13572468, 32'h24681357);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
